// File: rtl/dtc_stream_eval.sv
// dtc_stream_eval: sequential decision-tree classifier over binary feature
// vectors. One tree level is evaluated per clock from a run-time loadable
// node table; results leave through a valid/ready handshake.
// Optional build macro DTC_ERR_EN: adds the out_err port and an 8-bit
// saturating abort counter (err_cnt).
module dtc_stream_eval #(
  parameter int N_FEAT        = 12,
  parameter int CLS_W         = 3,
  parameter int NODES         = 32,
  parameter int MAX_DEPTH     = 8,
  parameter int DEFAULT_CLASS = 0,
  localparam int FEAT_W  = $clog2(N_FEAT),
  localparam int ADDR_W  = $clog2(NODES),
  localparam int DEP_W   = $clog2(MAX_DEPTH + 1),
  localparam int ENTRY_W = 1 + FEAT_W + 2 * ADDR_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [N_FEAT-1:0]  in_feat,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [CLS_W-1:0]   out_class,
  output logic [DEP_W-1:0]   out_depth,
`ifdef DTC_ERR_EN
  output logic               out_err,
`endif
  input  logic               cfg_we,
  input  logic [ADDR_W-1:0]  cfg_addr,
  input  logic [ENTRY_W-1:0] cfg_wdata
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WALK = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [CLS_W-1:0]   DEF_CLS     = CLS_W'(DEFAULT_CLASS);
  localparam logic [DEP_W-1:0]   DEPTH_LIMIT = DEP_W'(MAX_DEPTH);
  // A leaf returning the default class: the table contents after reset.
  localparam logic [ENTRY_W-1:0] RESET_ENTRY = {1'b1, {(ENTRY_W-1-CLS_W){1'b0}}, DEF_CLS};

  logic [1:0]         state_q, state_d;
  logic [ENTRY_W-1:0] table_q [NODES];
  logic [N_FEAT-1:0]  feat_q, feat_d;
  logic [ADDR_W-1:0]  ptr_q, ptr_d;
  logic [DEP_W-1:0]   steps_q, steps_d;
  logic [CLS_W-1:0]   class_q, class_d;
  logic [DEP_W-1:0]   depth_q, depth_d;

  // Decoded fields of the node currently pointed at.
  logic [ENTRY_W-1:0] entry_s;
  logic               leaf_s;
  logic [FEAT_W-1:0]  node_feat_s;
  logic [ADDR_W-1:0]  child1_s, child0_s, next_s;
  logic               feat_ok_s, child_ok_s, addr_ok_s, feat_bit_s;
  logic               abort_s, accept_s;

  assign entry_s     = table_q[ptr_q];
  assign leaf_s      = entry_s[ENTRY_W-1];
  assign node_feat_s = entry_s[ENTRY_W-2 -: FEAT_W];
  assign child1_s    = entry_s[2*ADDR_W-1 -: ADDR_W];
  assign child0_s    = entry_s[ADDR_W-1:0];

  // Range checks collapse to constants when the field covers exactly the
  // legal range, so no always-true comparison is built in that case.
  if (N_FEAT == (1 << FEAT_W)) begin : g_feat_full
    assign feat_ok_s = 1'b1;
  end else begin : g_feat_part
    assign feat_ok_s = (32'(node_feat_s) < 32'(N_FEAT));
  end

  if (NODES == (1 << ADDR_W)) begin : g_node_full
    assign child_ok_s = 1'b1;
    assign addr_ok_s  = 1'b1;
  end else begin : g_node_part
    assign child_ok_s = (32'(next_s) < 32'(NODES));
    assign addr_ok_s  = (32'(cfg_addr) < 32'(NODES));
  end

  // An out-of-range feature index never selects a real bit.
  assign feat_bit_s = feat_ok_s ? feat_q[node_feat_s] : 1'b0;
  assign next_s     = feat_bit_s ? child1_s : child0_s;
  assign abort_s    = ~leaf_s & ((steps_q == DEPTH_LIMIT) | ~feat_ok_s | ~child_ok_s);

  // in_ready may follow out_ready combinationally; it is held low in reset.
  assign in_ready  = ~rst & ((state_q == ST_IDLE) | ((state_q == ST_DONE) & out_ready));
  assign accept_s  = in_valid & ((state_q == ST_IDLE) | ((state_q == ST_DONE) & out_ready));
  assign out_valid = (state_q == ST_DONE);
  assign out_class = class_q;
  assign out_depth = depth_q;

  // Next-state logic for the walk FSM and the result registers.
  always_comb begin
    state_d = state_q;
    feat_d  = feat_q;
    ptr_d   = ptr_q;
    steps_d = steps_q;
    class_d = class_q;
    depth_d = depth_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          state_d = ST_WALK;
          feat_d  = in_feat;
          ptr_d   = '0;
          steps_d = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WALK: begin
        if (leaf_s) begin
          class_d = entry_s[CLS_W-1:0];
          depth_d = steps_q;
          state_d = ST_DONE;
        end else if (abort_s) begin
          class_d = DEF_CLS;
          depth_d = steps_q;
          state_d = ST_DONE;
        end else begin
          ptr_d   = next_s;
          steps_d = steps_q + DEP_W'(1);
          state_d = ST_WALK;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          if (in_valid) begin
            state_d = ST_WALK;
            feat_d  = in_feat;
            ptr_d   = '0;
            steps_d = '0;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM, walk pointer and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      feat_q  <= '0;
      ptr_q   <= '0;
      steps_q <= '0;
      class_q <= DEF_CLS;
      depth_q <= '0;
    end else begin
      state_q <= state_d;
      feat_q  <= feat_d;
      ptr_q   <= ptr_d;
      steps_q <= steps_d;
      class_q <= class_d;
      depth_q <= depth_d;
    end
  end

  // Node table: reset to default-class leaves, written through the cfg port.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NODES; i++) begin
        table_q[i] <= RESET_ENTRY;
      end
    end else if (cfg_we && addr_ok_s) begin
      table_q[cfg_addr] <= cfg_wdata;
    end
  end

`ifdef DTC_ERR_EN
  logic       err_q;
  logic [7:0] err_cnt;
  logic       walk_end_s;

  assign walk_end_s = (state_q == ST_WALK) & (leaf_s | abort_s);
  assign out_err    = err_q;

  // Abort flag for the current result and saturating abort counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q   <= 1'b0;
      err_cnt <= 8'd0;
    end else begin
      if (walk_end_s) begin
        err_q <= abort_s;
      end
      if (walk_end_s && abort_s && (err_cnt != 8'hFF)) begin
        err_cnt <= err_cnt + 8'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_dtc_stream_eval.sv
// Self-checking bench for dtc_stream_eval: a software tree walk predicts each
// result into a scoreboard when a vector is accepted; results are popped and
// compared when out_valid is seen.
module tb_dtc_stream_eval;
  localparam int N_FEAT = 12, CLS_W = 3, NODES = 32, MAX_DEPTH = 8;
  localparam int ADDR_W = 5, DEP_W = 4, ENTRY_W = 15;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic [N_FEAT-1:0]  in_feat = '0;
  logic               out_valid;
  logic               out_ready = 1'b1;
  logic [CLS_W-1:0]   out_class;
  logic [DEP_W-1:0]   out_depth;
`ifdef DTC_ERR_EN
  logic               out_err;
`endif
  logic               cfg_we = 1'b0;
  logic [ADDR_W-1:0]  cfg_addr = '0;
  logic [ENTRY_W-1:0] cfg_wdata = '0;

  dtc_stream_eval dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_feat(in_feat),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_class(out_class), .out_depth(out_depth),
`ifdef DTC_ERR_EN
    .out_err(out_err),
`endif
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic             err;
    logic [DEP_W-1:0] depth;
    logic [CLS_W-1:0] cls;
  } res_t;

  res_t               sb[$];
  logic [ENTRY_W-1:0] mt [NODES];
  int                 tests_run = 0;
  int                 tests_failed = 0;

  localparam logic [ENTRY_W-1:0] LEAF0 = {1'b1, 11'd0, 3'd0};

  function automatic logic [ENTRY_W-1:0] leaf(input logic [2:0] c);
    return {1'b1, 11'd0, c};
  endfunction

  function automatic logic [ENTRY_W-1:0] inode(input int f, input int c1, input int c0);
    return {1'b0, 4'(f), 5'(c1), 5'(c0)};
  endfunction

  // Reference tree walk over the bench's copy of the table.
  function automatic res_t model(input logic [N_FEAT-1:0] f);
    res_t r;
    logic [ADDR_W-1:0] p;
    logic [ENTRY_W-1:0] e;
    int fi;
    p = '0;
    r = '0;
    for (int s = 0; s <= MAX_DEPTH; s++) begin
      e = mt[p];
      if (e[14]) begin
        r.err = 1'b0; r.depth = 4'(s); r.cls = e[2:0];
        return r;
      end
      fi = int'(e[13:10]);
      if (s == MAX_DEPTH || fi >= N_FEAT) begin
        r.err = 1'b1; r.depth = 4'(s); r.cls = 3'd0;
        return r;
      end
      p = f[fi] ? e[9:5] : e[4:0];
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < NODES; i++) mt[i] = LEAF0;
  endtask

  task automatic cfg_write(input logic [ADDR_W-1:0] a, input logic [ENTRY_W-1:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
    tick();
    cfg_we = 1'b0;
    mt[a] = d;
  endtask

  // Offer one vector, push its prediction at the accepting edge, then
  // scramble in_feat to show the latched copy is what gets walked.
  task automatic send(input logic [N_FEAT-1:0] f);
    int n = 0;
    while (in_ready !== 1'b1 && n < 50) begin tick(); n++; end
    tests_run++;
    if (in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL send_ready: in_ready=%b, required 1", in_ready);
    end
    in_valid = 1'b1; in_feat = f;
    sb.push_back(model(f));
    tick();
    in_valid = 1'b0; in_feat = ~f;
  endtask

  // Wait (bounded) for out_valid; returns edges counted.
  task automatic wait_out(output int lat);
    lat = 0;
    do begin tick(); lat++; end while (out_valid !== 1'b1 && lat < 40);
    tests_run++;
    if (out_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL wait_out: out_valid=%b after %0d edges, required 1", out_valid, lat);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    tests_run++;
    if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL rst_in_ready: got %b need 0", in_ready); end
    rst = 1'b0;
    #1;
    tests_run++;
    if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL post_rst_in_ready: got %b need 1", in_ready); end
    tests_run++;
    if ({out_valid, out_class, out_depth} !== {1'b0, 3'd0, 4'd0}) begin
      tests_failed++;
      $display("FAIL rst_outputs: valid/class/depth=%b/%0d/%0d need 0/0/0", out_valid, out_class, out_depth);
    end
`ifdef DTC_ERR_EN
    tests_run++;
    if (out_err !== 1'b0 || dut.err_cnt !== 8'd0) begin
      tests_failed++;
      $display("FAIL rst_err: err=%b cnt=%0d need 0/0", out_err, dut.err_cnt);
    end
`endif
    model_reset();
    sb.delete();
  endtask

  task automatic test_default_table();
    res_t exp;
    int lat;
    send(12'hFFF);
    wait_out(lat);
    exp = sb.pop_front();
    tests_run++;
    if (lat !== 1) begin tests_failed++; $display("FAIL default_latency: got %0d need 1", lat); end
    tests_run++;
    if ({out_depth, out_class} !== {exp.depth, exp.cls} || exp.cls !== 3'd0) begin
      tests_failed++;
      $display("FAIL default_result: depth/class=%0d/%0d need %0d/0", out_depth, out_class, exp.depth);
    end
`ifdef DTC_ERR_EN
    tests_run++;
    if (out_err !== 1'b0) begin tests_failed++; $display("FAIL default_err: got %b need 0", out_err); end
`endif
  endtask

  task automatic test_tree();
    logic [N_FEAT-1:0] pats [4];
    res_t exp;
    int lat;
    pats[0] = 12'h048; pats[1] = 12'h010; pats[2] = 12'h040; pats[3] = 12'h000;
    cfg_write(5'd0, inode(6, 2, 1));
    cfg_write(5'd1, inode(4, 4, 3));
    cfg_write(5'd2, inode(3, 6, 5));
    cfg_write(5'd3, leaf(3'd0));
    cfg_write(5'd4, leaf(3'd4));
    cfg_write(5'd5, leaf(3'd1));
    cfg_write(5'd6, leaf(3'd7));
    for (int i = 0; i < 4; i++) begin
      send(pats[i]);
      wait_out(lat);
      exp = sb.pop_front();
      tests_run++;
      if ({out_depth, out_class} !== {exp.depth, exp.cls} || lat !== int'(exp.depth) + 1) begin
        tests_failed++;
        $display("FAIL tree_%0d: depth/class/lat=%0d/%0d/%0d need %0d/%0d/%0d",
                 i, out_depth, out_class, lat, exp.depth, exp.cls, int'(exp.depth) + 1);
      end
    end
  endtask

  task automatic test_back_to_back();
    res_t exp;
    int acc = 0, got = 0, cyc = 0, last = -1;
    tick();
    out_ready = 1'b1; in_feat = 12'h048;
    while (got < 3 && cyc < 40) begin
      in_valid = (acc < 3);
      if (in_valid && in_ready) begin sb.push_back(model(in_feat)); acc++; end
      tick(); cyc++;
      if (out_valid === 1'b1) begin
        exp = sb.pop_front();
        tests_run++;
        if ({out_depth, out_class} !== {exp.depth, exp.cls}) begin
          tests_failed++;
          $display("FAIL b2b_result: depth/class=%0d/%0d need %0d/%0d", out_depth, out_class, exp.depth, exp.cls);
        end
        if (last >= 0) begin
          tests_run++;
          if (cyc - last !== 4) begin tests_failed++; $display("FAIL b2b_spacing: got %0d need 4", cyc - last); end
        end
        last = cyc; got++;
      end
    end
    in_valid = 1'b0;
    tests_run++;
    if (got !== 3) begin tests_failed++; $display("FAIL b2b_count: got %0d need 3", got); end
  endtask

  task automatic test_backpressure();
    res_t exp;
    int lat;
    tick();
    out_ready = 1'b0;
    send(12'h010);
    wait_out(lat);
    exp = sb.pop_front();
    for (int i = 0; i < 10; i++) begin
      tests_run++;
      if ({out_valid, in_ready, out_depth, out_class} !== {1'b1, 1'b0, exp.depth, exp.cls}) begin
        tests_failed++;
        $display("FAIL bp_hold_%0d: valid/ready/depth/class=%b/%b/%0d/%0d need 1/0/%0d/%0d",
                 i, out_valid, in_ready, out_depth, out_class, exp.depth, exp.cls);
      end
      tick();
    end
    in_valid = 1'b1; in_feat = 12'h040; out_ready = 1'b1;
    #1;
    tests_run++;
    if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL bp_release_ready: got %b need 1", in_ready); end
    sb.push_back(model(in_feat));
    tick();
    in_valid = 1'b0;
    tests_run++;
    if ({out_valid, in_ready} !== 2'b00) begin
      tests_failed++;
      $display("FAIL bp_no_idle: valid/ready=%b/%b need 0/0", out_valid, in_ready);
    end
    wait_out(lat);
    exp = sb.pop_front();
    tests_run++;
    if ({out_depth, out_class} !== {exp.depth, exp.cls} || lat !== int'(exp.depth) + 1) begin
      tests_failed++;
      $display("FAIL bp_second: depth/class/lat=%0d/%0d/%0d need %0d/%0d/%0d",
               out_depth, out_class, lat, exp.depth, exp.cls, int'(exp.depth) + 1);
    end
  endtask

  task automatic test_abort();
    res_t exp;
    int lat;
    cfg_write(5'd0, inode(0, 0, 0));
    send(12'h5A5);
    wait_out(lat);
    exp = sb.pop_front();
    tests_run++;
    if ({out_depth, out_class} !== {4'd8, 3'd0} || exp.depth !== 4'd8 || lat !== 9) begin
      tests_failed++;
      $display("FAIL loop_abort: depth/class/lat=%0d/%0d/%0d need 8/0/9", out_depth, out_class, lat);
    end
`ifdef DTC_ERR_EN
    tests_run++;
    if (out_err !== 1'b1 || dut.err_cnt !== 8'd1) begin
      tests_failed++;
      $display("FAIL loop_err: err=%b cnt=%0d need 1/1", out_err, dut.err_cnt);
    end
`endif
    cfg_write(5'd0, inode(13, 3, 3));
    send(12'hFFF);
    wait_out(lat);
    exp = sb.pop_front();
    tests_run++;
    if ({out_depth, out_class} !== {exp.depth, exp.cls} || lat !== 1) begin
      tests_failed++;
      $display("FAIL feat_abort: depth/class/lat=%0d/%0d/%0d need %0d/%0d/1", out_depth, out_class, lat, exp.depth, exp.cls);
    end
`ifdef DTC_ERR_EN
    tests_run++;
    if (out_err !== exp.err || dut.err_cnt !== 8'd2) begin
      tests_failed++;
      $display("FAIL feat_err: err=%b cnt=%0d need %b/2", out_err, dut.err_cnt, exp.err);
    end
`endif
  endtask

  task automatic test_cfg_during_walk();
    res_t exp;
    int lat;
    cfg_write(5'd0, inode(0, 1, 1));
    cfg_write(5'd1, inode(0, 2, 2));
    cfg_write(5'd2, inode(0, 3, 3));
    cfg_write(5'd3, leaf(3'd5));
    send(12'h000);
    tick(); tick();
    cfg_we = 1'b1; cfg_addr = 5'd0; cfg_wdata = leaf(3'd2);
    tick();
    cfg_we = 1'b0; mt[0] = leaf(3'd2);
    wait_out(lat);
    exp = sb.pop_front();
    tests_run++;
    if ({out_depth, out_class} !== {exp.depth, exp.cls} || exp.cls !== 3'd5) begin
      tests_failed++;
      $display("FAIL cfg_walk_cur: depth/class=%0d/%0d need %0d/5", out_depth, out_class, exp.depth);
    end
    send(12'h000);
    wait_out(lat);
    exp = sb.pop_front();
    tests_run++;
    if ({out_depth, out_class} !== {exp.depth, exp.cls} || exp.cls !== 3'd2) begin
      tests_failed++;
      $display("FAIL cfg_walk_next: depth/class=%0d/%0d need %0d/2", out_depth, out_class, exp.depth);
    end
  endtask

  task automatic test_reset_mid_walk();
    res_t exp;
    int lat;
    int seen = 0;
    cfg_write(5'd0, inode(0, 0, 0));
    send(12'h000);
    tick(); tick(); tick();
    rst = 1'b1;
    #1;
    tests_run++;
    if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL midrst_in_ready: got %b need 0", in_ready); end
    tick();
    rst = 1'b0;
    sb.delete();
    model_reset();
    #1;
    tests_run++;
    if ({in_ready, out_valid} !== 2'b10) begin
      tests_failed++;
      $display("FAIL midrst_after: ready/valid=%b/%b need 1/0", in_ready, out_valid);
    end
    for (int i = 0; i < 12; i++) begin
      tick();
      if (out_valid !== 1'b0) seen++;
    end
    tests_run++;
    if (seen !== 0) begin tests_failed++; $display("FAIL midrst_no_output: out_valid high %0d cycles, need 0", seen); end
`ifdef DTC_ERR_EN
    tests_run++;
    if (dut.err_cnt !== 8'd0) begin tests_failed++; $display("FAIL midrst_cnt: got %0d need 0", dut.err_cnt); end
`endif
    send(12'hABC);
    wait_out(lat);
    exp = sb.pop_front();
    tests_run++;
    if ({out_depth, out_class} !== {exp.depth, exp.cls} || lat !== 1) begin
      tests_failed++;
      $display("FAIL midrst_table: depth/class/lat=%0d/%0d/%0d need %0d/%0d/1", out_depth, out_class, lat, exp.depth, exp.cls);
    end
  endtask

  initial begin
    test_reset();
    test_default_table();
    test_tree();
    test_back_to_back();
    test_backpressure();
    test_abort();
    test_cfg_during_walk();
    test_reset_mid_walk();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/dtc_stream_eval.md
# dtc_stream_eval

Programmable, sequential decision-tree classifier for binary feature vectors. It walks one tree level per clock through a run-time-loadable node table and returns a class index, with valid/ready handshakes on both sides. It supersedes the fixed, combinational, per-benchmark tree netlists. Any tree up to NODES nodes and MAX_DEPTH levels is loaded through a config port instead of being re-synthesised.

## Interface
- N_FEAT, 12: feature vector width; FEAT_W = clog2(N_FEAT).
- CLS_W, 3: class index width.
- NODES, 32: node table depth; ADDR_W = clog2(NODES). Constraint: 2*ADDR_W >= CLS_W.
- MAX_DEPTH, 8: maximum internal nodes traversed before abort; DEP_W = clog2(MAX_DEPTH+1).
- DEFAULT_CLASS, 0: class used for the reset table contents and for aborts.
- Derived ENTRY_W = 1+FEAT_W+2*ADDR_W.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  feature vector valid.
- in_ready  out  1  block can accept a vector.
- in_feat  in  N_FEAT  binary feature vector.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_class  out  CLS_W  class index.
- out_depth  out  DEP_W  number of internal nodes traversed.
- out_err  out  1  abort flag; present only with DTC_ERR_EN.
- cfg_we  in  1  node table write strobe.
- cfg_addr  in  ADDR_W  node table write address.
- cfg_wdata  in  ENTRY_W  node entry.

## Operation
- Entry layout, MSB to LSB: {leaf, feat, child1, child0}.
  - Internal node (leaf=0): next = in_feat[feat] ? child1 : child0.
  - Leaf node (leaf=1): class = entry[CLS_W-1:0]; the other bits are ignored.
- Node table is flops. Reset writes every entry to {1, 0, …, DEFAULT_CLASS}, i.e. a leaf returning DEFAULT_CLASS.
- cfg writes may occur in any cycle, including during a walk. A write is visible to reads starting the cycle after the write edge. Addresses >= NODES are ignored.
- FSM states:
  - IDLE: in_ready=1. On in_valid, latch in_feat, set ptr=0 and steps=0, go to WALK.
  - WALK: evaluate table[ptr].
    - Leaf: latch the class, out_depth=steps, err=0, go to DONE.
    - Internal with steps==MAX_DEPTH, a selected child >= NODES, or feat >= N_FEAT: abort. Class = DEFAULT_CLASS, out_depth=steps, err=1, go to DONE.
    - Otherwise: ptr=next, steps+1, stay in WALK.
  - DONE: out_valid=1. Outputs stay stable until out_ready.
    - On out_ready with in_valid: accept the new vector in the same edge and go to WALK.
    - On out_ready without in_valid: go to IDLE.
- in_ready = (state==IDLE) || (state==DONE && out_ready).
- A latched vector is immune to in_feat changes during the walk.
- rst during any state: return to IDLE and drop any in-flight vector without producing output.

## Timing
- Reset values:
  - in_ready=0 during reset, 1 in the first cycle after reset.
  - out_valid=0, out_class=DEFAULT_CLASS, out_depth=0, out_err=0.
- Latency for a leaf at depth d (d internal nodes above it): out_valid rises d+1 edges after the accepting edge. Minimum is 1 (root is a leaf). Maximum is MAX_DEPTH+1.
- Throughput: one result per d+2 cycles with out_ready held high.
- There is no combinational path from in_valid or in_feat to any output. out_ready feeds in_ready combinationally.

## Configuration
- DTC_ERR_EN defined:
  - out_err port exists and is registered as described.
  - Aborts count in a saturating 8-bit internal counter, cleared by rst, readable hierarchically as err_cnt.
- Undefined:
  - No out_err port and no counter.
  - Abort behaviour is otherwise identical: DEFAULT_CLASS, out_depth=steps.

## Test plan
- Reset, no programming: in_feat=12'hFFF -> out_class=0, out_depth=0, out_valid one edge after accept, out_err=0.
- Program a 3-level tree:
  - node0={0,6,2,1}, node1={0,4,4,3}, node2={0,3,6,5}.
  - node3..6 leaves with classes 0, 4, 1, 7.
  - in_feat bit6=1, bit3=1 -> class 7, depth 2, latency 3.
  - bit6=0, bit4=1 -> class 4.
- Loop table node0 child0=child1=0: any input -> abort after MAX_DEPTH=8 steps, class DEFAULT_CLASS, out_depth=8, out_err=1 (macro on), err_cnt=1.
- Backpressure: hold out_ready=0 for 10 cycles in DONE -> outputs stable, in_ready=0. Then out_ready=1 with in_valid=1 -> new vector accepted on the same edge with no IDLE cycle.
- Write node0 during a walk at ptr=2 -> current result unchanged; the next vector uses the new node0.
- Assert rst mid-walk at step 3 -> no out_valid. Next cycle in_ready=1 and the table is back to all DEFAULT_CLASS leaves.
